// File: rtl/dataset_pkg.sv
// Shared constants, FSM state type and slot-select helper for the dataset RAM readers.
package dataset_pkg;
  localparam int LENGTH_W     = 16;
  localparam int MAX_FEATURES = 15;
  localparam int SLOT_W       = $clog2(MAX_FEATURES + 1);
  localparam int ROW_W        = LENGTH_W * (MAX_FEATURES + 1);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, CAPTURE, STREAM, DONE} state_e;

  // Slot MAX_FEATURES holds y; lower slots hold features.
  function automatic logic [LENGTH_W-1:0] slot_select(input logic [ROW_W-1:0]  row,
                                                      input logic [SLOT_W-1:0] slot);
    return row[int'(slot) * LENGTH_W +: LENGTH_W];
  endfunction
endpackage

// File: rtl/row_slot_mux.sv
// Combinational selection of one LENGTH_W-bit slot from a dataset RAM row.
module row_slot_mux
  import dataset_pkg::*;
(
  input  logic [ROW_W-1:0]    row,
  input  logic [SLOT_W-1:0]   slot,
  output logic [LENGTH_W-1:0] word
);
  assign word = slot_select(row, slot);
endmodule

// File: rtl/dataset_row_streamer.sv
// Reads dataset RAM rows and streams features then y as 16-bit valid/ready words.
// Optional multi-epoch replay is enabled by defining STREAM_EPOCHS_EN.
module dataset_row_streamer
  import dataset_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 100,
  parameter int RD_LAT     = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_points,
  input  logic [3:0]            num_features,
`ifdef STREAM_EPOCHS_EN
  input  logic [7:0]            num_epochs,
  output logic                  epoch_last,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_oe,
  output logic                  ram_we,
  input  logic [ROW_W-1:0]      ram_data,
  output logic [LENGTH_W-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_is_y,
  output logic                  out_last
);
  localparam logic [SLOT_W-1:0] Y_SLOT = SLOT_W'(MAX_FEATURES);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] np_q, np_d;
  logic [3:0]            nf_q, nf_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [1:0]            wait_q, wait_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic                  oe_q, oe_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef STREAM_EPOCHS_EN
  logic [7:0]            ep_q, ep_d;
  logic                  ep_last_q, ep_last_d;
`endif

  logic                  last_row;
  logic                  is_y_slot;
  logic                  final_epoch;
  logic [LENGTH_W-1:0]   mux_word;

  assign last_row  = (addr_q == np_q - ADDR_WIDTH'(1));
  assign is_y_slot = (slot_q == Y_SLOT);
`ifdef STREAM_EPOCHS_EN
  assign final_epoch = (ep_q == 8'd1);
`else
  assign final_epoch = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    np_d    = np_q;
    nf_d    = nf_q;
    slot_d  = slot_q;
    wait_d  = wait_q;
    row_d   = row_q;
`ifdef STREAM_EPOCHS_EN
    ep_d      = ep_q;
    ep_last_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          np_d    = (num_points > ADDR_WIDTH'(DEPTH)) ? ADDR_WIDTH'(DEPTH) : num_points;
          nf_d    = num_features;
          addr_d  = '0;
`ifdef STREAM_EPOCHS_EN
          ep_d    = (num_epochs == 8'd0) ? 8'd1 : num_epochs;
`endif
          state_d = (num_points == '0) ? DONE : ADDR;
        end
      end
      ADDR: begin
        wait_d  = 2'(RD_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == 2'd0) state_d = CAPTURE;
        else                wait_d  = wait_q - 2'd1;
      end
      CAPTURE: begin
        row_d   = ram_data;
        slot_d  = (nf_q == 4'd0) ? Y_SLOT : '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (out_ready) begin
          // Unused feature slots between num_features-1 and y are skipped.
          if (!is_y_slot) begin
            slot_d = (slot_q == SLOT_W'(nf_q - 4'd1)) ? Y_SLOT : slot_q + SLOT_W'(1);
          end else if (!last_row) begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = ADDR;
          end else if (!final_epoch) begin
`ifdef STREAM_EPOCHS_EN
            ep_d      = ep_q - 8'd1;
            ep_last_d = 1'b1;
`endif
            addr_d  = '0;
            state_d = ADDR;
          end else begin
`ifdef STREAM_EPOCHS_EN
            ep_last_d = 1'b1;
`endif
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    oe_d    = (state_d == ADDR) || (state_d == WAIT) || (state_d == CAPTURE);
    valid_d = (state_d == STREAM);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      np_q    <= '0;
      nf_q    <= '0;
      slot_q  <= '0;
      wait_q  <= '0;
      row_q   <= '0;
      oe_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef STREAM_EPOCHS_EN
      ep_q      <= '0;
      ep_last_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      np_q    <= np_d;
      nf_q    <= nf_d;
      slot_q  <= slot_d;
      wait_q  <= wait_d;
      row_q   <= row_d;
      oe_q    <= oe_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef STREAM_EPOCHS_EN
      ep_q      <= ep_d;
      ep_last_q <= ep_last_d;
`endif
    end
  end

  row_slot_mux u_slot_mux (
    .row  (row_q),
    .slot (slot_q),
    .word (mux_word)
  );

  assign ram_addr  = addr_q;
  assign ram_oe    = oe_q;
  assign ram_we    = 1'b0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  // Word outputs are gated so they read zero whenever no word is offered.
  assign out_data  = valid_q ? mux_word : '0;
  assign out_is_y  = valid_q & is_y_slot;
  assign out_last  = valid_q & is_y_slot & last_row & final_epoch;
`ifdef STREAM_EPOCHS_EN
  assign epoch_last = ep_last_q;
`endif
endmodule
